// File: rtl/vga_pkg.sv
// Shared VGA constants, button indices and the cursor state record.
package vga_pkg;

    localparam int NUM_CUADROS = 16;
    localparam int RESOL_X     = 640;
    localparam int RESOL_Y     = 480;
    localparam int MARCO_X     = 144;
    localparam int MARCO_Y     = 32;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 521;

    localparam logic [2:0] RGB_MARCO   = 3'b000;
    localparam logic [3:0] POS_RESET   = 4'd7;
    localparam logic [2:0] COLOR_RESET = 3'b100;

    localparam int NUM_BTNS  = 5;
    localparam int NUM_DIRS  = 4;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_COLOR = 4;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] rgb;
    } cursor_t;

    // Skips RGB_MARCO so the square never blends into the black border.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == 3'b111) ? 3'b001 : c + 3'b001;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// 2-FF synchronizer plus stable-level debouncer; emits the debounced level and a rising pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            rise <= accept & sync[1];
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/square_cursor_ctrl.sv
// Button-driven cursor position/color for the VGA grid; updates land only on the frame tick.
module square_cursor_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_FRAMES   = 30,
    parameter int FRAME_TICK_LINE = 512
) (
    input  logic       Clock25,
    input  logic       Reset,
    input  logic       iBtnUp,
    input  logic       iBtnDown,
    input  logic       iBtnLeft,
    input  logic       iBtnRight,
    input  logic       iBtnColor,
    input  logic [9:0] iCont_X,
    input  logic [9:0] iCont_Y,
    output logic [3:0] oPosicionX,
    output logic [3:0] oPosicionY,
    output logic [2:0] oColorCuadro,
    output logic       oFrameTick
);
    localparam int HW = $clog2(REPEAT_FRAMES + 1);

    logic [NUM_BTNS-1:0] btn_raw, btn_lvl, btn_rise, hold_fire, pend;
    logic                tick_cond, tick_q;
    cursor_t             cur;

    assign btn_raw   = {iBtnColor, iBtnRight, iBtnLeft, iBtnDown, iBtnUp};
    assign tick_cond = (iCont_X == 10'd0) && (iCont_Y == 10'(FRAME_TICK_LINE));

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .gclk   (Clock25),
            .grst_n (Reset),
            .btn_raw(btn_raw[i]),
            .level  (btn_lvl[i]),
            .rise   (btn_rise[i])
        );

        if (i < NUM_DIRS) begin : g_hold
            logic [HW-1:0] hold;
            assign hold_fire[i] = tick_cond && btn_lvl[i] && (hold == HW'(REPEAT_FRAMES - 1));
            always_ff @(posedge Clock25 or negedge Reset) begin
                if (!Reset)             hold <= '0;
                else if (!btn_lvl[i])   hold <= '0;
                else if (hold_fire[i])  hold <= '0;
                else if (tick_cond)     hold <= hold + 1'b1;
            end
        end else begin : g_nohold
            assign hold_fire[i] = 1'b0;
        end
    end

    // A rise coinciding with the tick survives the clear and is applied next frame.
    // The level gate is redundant with rise but keeps every debounced level in use.
    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) pend <= '0;
        else        pend <= (tick_cond ? '0 : pend) | (btn_rise & btn_lvl) | hold_fire;
    end

    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) begin
            cur    <= '{x: POS_RESET, y: POS_RESET, rgb: COLOR_RESET};
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_cond;
            if (tick_cond) begin
                case ({pend[BTN_RIGHT], pend[BTN_LEFT]})
                    2'b10:   cur.x <= cur.x + 4'd1;
                    2'b01:   cur.x <= cur.x - 4'd1;
                    default: cur.x <= cur.x;
                endcase
                case ({pend[BTN_DOWN], pend[BTN_UP]})
                    2'b10:   cur.y <= cur.y + 4'd1;
                    2'b01:   cur.y <= cur.y - 4'd1;
                    default: cur.y <= cur.y;
                endcase
                if (pend[BTN_COLOR]) cur.rgb <= next_color(cur.rgb);
            end
        end
    end

    assign oPosicionX   = cur.x;
    assign oPosicionY   = cur.y;
    assign oColorCuadro = cur.rgb;
    assign oFrameTick   = tick_q;

endmodule

// File: tb/tb_square_cursor_ctrl.sv
// Directed scoreboard bench for square_cursor_ctrl on a compressed 4x21-line frame.
module tb_square_cursor_ctrl;

    localparam int DB = 4;
    localparam int RF = 3;
    localparam int LINE_LEN = 4;
    localparam int FRAME_LEN = LINE_LEN * 21;
    localparam int HOLD_TICKS = 8;

    localparam logic [4:0] M_UP = 5'b00001, M_DN = 5'b00010, M_LT = 5'b00100,
                           M_RT = 5'b01000, M_CL = 5'b10000;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] c;
    } exp_t;

    logic       clk, rst_n;
    logic [4:0] btn;
    logic [9:0] cont_x, cont_y;
    logic [3:0] pos_x, pos_y;
    logic [2:0] color;
    logic       ftick;

    int   checks = 0, failures = 0;
    int   cyc = 0, last_tick_cyc = 0, tick_period = 0;
    exp_t sb[$];
    logic [3:0] ex, ey;
    logic [2:0] ec;

    square_cursor_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_FRAMES(RF), .FRAME_TICK_LINE(512)) dut (
        .Clock25(clk), .Reset(rst_n),
        .iBtnUp(btn[0]), .iBtnDown(btn[1]), .iBtnLeft(btn[2]), .iBtnRight(btn[3]), .iBtnColor(btn[4]),
        .iCont_X(cont_x), .iCont_Y(cont_y),
        .oPosicionX(pos_x), .oPosicionY(pos_y), .oColorCuadro(color), .oFrameTick(ftick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shortened raster: only lines 500..520 are visited so that line 512 recurs quickly.
    initial begin
        cont_x = '0;
        cont_y = 10'd500;
        forever begin
            @(negedge clk);
            cyc++;
            if (cont_x == 10'(LINE_LEN - 1)) begin
                cont_x = '0;
                cont_y = (cont_y == 10'd520) ? 10'd500 : cont_y + 10'd1;
            end else begin
                cont_x = cont_x + 10'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_check(input string tag);
        int   n;
        logic seen;
        exp_t e;
        n = 0;
        seen = 1'b0;
        while (n < 4 * FRAME_LEN) begin
            @(negedge clk); #1;
            if (ftick) begin seen = 1'b1; break; end
            n++;
        end
        chk({tag, "_tick_seen"}, 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                tick_period   = cyc - last_tick_cyc;
                last_tick_cyc = cyc;
                chk({tag, "_x"}, 32'(pos_x), 32'(e.x));
                chk({tag, "_y"}, 32'(pos_y), 32'(e.y));
                chk({tag, "_color"}, 32'(color), 32'(e.c));
                chk({tag, "_nonzero_color"}, 32'(color != 3'b000), 32'd1);
                chk({tag, "_tick_x"}, 32'(cont_x), 32'd1);
                chk({tag, "_tick_y"}, 32'(cont_y), 32'd512);
                @(negedge clk); #1;
                chk({tag, "_tick_width"}, 32'(ftick), 32'd0);
            end
        end
    endtask

    task automatic step(input string tag);
        sb.push_back('{x: ex, y: ey, c: ec});
        tick_check(tag);
    endtask

    task automatic press(input logic [4:0] m, input int n);
        btn = btn | m;
        repeat (n) @(negedge clk);
        #1;
        btn = btn & ~m;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(pos_x), 32'd7);
        chk({tag, "_y"}, 32'(pos_y), 32'd7);
        chk({tag, "_color"}, 32'(color), 32'd4);
        chk({tag, "_tick"}, 32'(ftick), 32'd0);
    endtask

    logic [2:0] color_seq [7];

    initial begin
        color_seq = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4};
        btn   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        ex = 4'd7; ey = 4'd7; ec = 3'd4;

        for (int f = 0; f < 3; f++) begin
            step("idle");
            if (f > 0) chk("frame_period", 32'(tick_period), 32'(FRAME_LEN));
        end

        press(M_RT, 10);
        ex = ex + 4'd1;
        step("right_press");
        step("right_after");

        for (int i = 0; i < 8; i++) begin
            press(M_LT, 10);
            ex = ex - 4'd1;
            step("left_walk");
        end
        chk("at_x0", 32'(pos_x), 32'd0);
        press(M_LT, 10);
        ex = 4'd15;
        step("left_wrap");

        for (int i = 0; i < 8; i++) begin
            press(M_DN, 10);
            ey = ey + 4'd1;
            step("down_walk");
        end
        press(M_DN, 10);
        ey = 4'd0;
        step("down_wrap");

        press(M_UP | M_DN, 10);
        step("up_down_cancel");

        press(M_LT, 2);
        step("left_glitch");

        btn = btn | M_RT;
        for (int k = 0; k < 10; k++) begin
            if (k == 0 || ((k % RF) == 0 && (k - 1) < HOLD_TICKS)) ex = ex + 4'd1;
            step("right_hold");
            if (k == HOLD_TICKS - 1) btn = btn & ~M_RT;
        end

        for (int i = 0; i < 7; i++) begin
            press(M_CL, 10);
            ec = color_seq[i];
            step("color");
        end

        btn = btn | M_RT;
        ex = ex + 4'd1;
        step("hold_before_reset");
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset_hold");
        btn = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        ex = 4'd7; ey = 4'd7; ec = 3'd4;
        step("post_reset_hold");
        step("post_reset_hold");

        btn = M_LT;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset_debounce");
        btn = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset_db");
        step("post_reset_db");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
